// File: rtl/newton_divider_param.sv
// Newton-Raphson integer divider: quot = num / den, rem = num - quot*den (unsigned or signed).
// Latency: done rises ITERS+6 edges after the accepting edge, for every operand pair.
// Backpressure: start accepted only while available; result held in HOLD until start drops.
// Build option: define NEWTON_DIV0_EN to add the div0 output flag.
module newton_divider_param #(
  parameter int WIDTH  = 32,
  parameter int ITERS  = 3,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             available,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
`ifdef NEWTON_DIV0_EN
  ,
  output logic             div0
`endif
);

  // Reciprocal fixed point: F fraction bits, 2 integer bits (X lives in (1,2]).
  localparam int F    = WIDTH + 2;
  localparam int XW   = F + 2;
  localparam int ZW   = 2 * WIDTH + 8;       // wide enough for every product below
  localparam int LZW  = $clog2(WIDTH + 1);
  localparam int SHW  = $clog2(ZW + 1);
  localparam int CNTW = $clog2(ITERS + 1);

  // Seed line X0 = 48/17 - 32/17*D, minimax over D in [0.5,1).
  localparam logic [F+7:0]  K48 = ((F+8)'(48) << F) / (F+8)'(17);
  localparam logic [F+7:0]  K32 = ((F+8)'(32) << F) / (F+8)'(17);
  localparam logic [XW-1:0] C48 = XW'(K48);
  localparam logic [XW-1:0] C32 = XW'(K32);
  localparam logic [XW-1:0] TWO = {2'b10, {F{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_NORM, S_SEED, S_ITER, S_MUL, S_CORR1, S_CORR2, S_HOLD
  } state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [WIDTH-1:0]  num_r, den_r;
  logic [WIDTH:0]    an_r, ad_r;            // magnitudes, one spare bit so |MIN| fits
  logic              neg_q, neg_r, den0_r;
  logic [LZW-1:0]    lz_r;
  logic [F-1:0]      d_r;                   // normalised divisor, Q0.F in [0.5,1)
  logic [XW-1:0]     x_r;                   // reciprocal estimate
  logic [WIDTH+1:0]  q_r;                   // quotient magnitude estimate
  logic [WIDTH-1:0]  r_r;                   // final remainder magnitude

  logic [WIDTH:0]    num_x, den_x, an_c, ad_c;
  logic [LZW-1:0]    lz_c;
  logic              lz_found;
  logic [WIDTH-1:0]  dn_c;
  logic [XW-1:0]     x_seed, e_c, t_c, x_next;
  logic [SHW-1:0]    sh_c;
  logic [WIDTH+1:0]  q_c, q_n;
  logic signed [ZW-1:0] r_c, r_n, ad_s;
  logic [WIDTH-1:0]  q_lo, quot_c, rem_c;

  // Datapath: magnitudes, normalisation, seed, Newton step, product and correction step.
  always_comb begin
    num_x = {((SIGNED != 0) && num_r[WIDTH-1]), num_r};
    den_x = {((SIGNED != 0) && den_r[WIDTH-1]), den_r};
    an_c  = num_x[WIDTH] ? -num_x : num_x;
    ad_c  = den_x[WIDTH] ? -den_x : den_x;

    lz_c     = '0;
    lz_found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!lz_found && ad_c[i]) begin
        lz_found = 1'b1;
        lz_c     = LZW'(WIDTH - 1 - i);
      end
    end
    if (!lz_found) lz_c = LZW'(WIDTH);
    dn_c = WIDTH'(ad_c) << lz_c;

    x_seed = C48 - XW'((ZW'(C32) * ZW'(d_r)) >> F);
    e_c    = XW'((ZW'(d_r) * ZW'(x_r)) >> F);
    t_c    = TWO - e_c;
    x_next = XW'((ZW'(x_r) * ZW'(t_c)) >> F);

    // X ~ 2^(F+WIDTH-lz)/|den| in integer units, so this shift yields floor(|num|/|den|) approx.
    sh_c = SHW'(F + WIDTH) - SHW'(lz_r);
    q_c  = (WIDTH+2)'((ZW'(an_r) * ZW'(x_r)) >> sh_c);

    ad_s = $signed(ZW'(ad_r));
    r_c  = $signed(ZW'(an_r)) - $signed(ZW'(q_r)) * ad_s;
    q_n  = q_r;
    r_n  = r_c;
    if (r_c >= ad_s) begin
      q_n = q_r + (WIDTH+2)'(1);
      r_n = r_c - ad_s;
    end else if (r_c[ZW-1]) begin
      q_n = q_r - (WIDTH+2)'(1);
      r_n = r_c + ad_s;
    end

    q_lo   = WIDTH'(q_r);
    quot_c = neg_q ? -q_lo : q_lo;
    rem_c  = neg_r ? -r_r : r_r;
    if (den0_r) begin
      quot_c = '1;
      rem_c  = num_r;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      available <= 1'b1;
      done      <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      num_r     <= '0;
      den_r     <= '0;
      an_r      <= '0;
      ad_r      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      den0_r    <= 1'b0;
      lz_r      <= '0;
      d_r       <= '0;
      x_r       <= '0;
      q_r       <= '0;
      r_r       <= '0;
`ifdef NEWTON_DIV0_EN
      div0      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            num_r     <= num;
            den_r     <= den;
            available <= 1'b0;
            cnt       <= '0;
            state     <= S_NORM;
          end
        end
        S_NORM: begin
          an_r   <= an_c;
          ad_r   <= ad_c;
          neg_q  <= (SIGNED != 0) && (num_r[WIDTH-1] ^ den_r[WIDTH-1]);
          neg_r  <= (SIGNED != 0) && num_r[WIDTH-1];
          den0_r <= (den_r == '0);
          lz_r   <= lz_c;
          d_r    <= {dn_c, 2'b00};
          state  <= S_SEED;
        end
        S_SEED: begin
          x_r   <= x_seed;
          cnt   <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          x_r <= x_next;
          if (cnt == CNTW'(ITERS - 1)) begin
            cnt   <= '0;
            state <= S_MUL;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        S_MUL: begin
          q_r   <= q_c;
          state <= S_CORR1;
        end
        S_CORR1: begin
          q_r   <= q_n;
          state <= S_CORR2;
        end
        S_CORR2: begin
          q_r   <= q_n;
          r_r   <= WIDTH'(r_n);
          state <= S_HOLD;
        end
        S_HOLD: begin
          // First HOLD cycle publishes the result; afterwards wait for start to drop.
          if (!done) begin
            done <= 1'b1;
            quot <= quot_c;
            rem  <= rem_c;
`ifdef NEWTON_DIV0_EN
            div0 <= den0_r;
`endif
          end else if (!start) begin
            done      <= 1'b0;
            available <= 1'b1;
            state     <= S_IDLE;
`ifdef NEWTON_DIV0_EN
            div0      <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_newton_divider_param.sv
// Bench for newton_divider_param: unsigned and signed instances driven with identical stimulus.
// Each result is compared with a plain-arithmetic reference model; latency and handshake checked.
// Optional div0 flag is checked when NEWTON_DIV0_EN is defined.
module tb_newton_divider_param;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [31:0] num, den;
  logic        avail_u, done_u, avail_s, done_s;
  logic [31:0] quot_u, rem_u, quot_s, rem_s;
`ifdef NEWTON_DIV0_EN
  logic        div0_u, div0_s;
`endif

  int n_tests;
  int n_fail;

  logic [31:0] ra, rb;
  int          rh;
  bit          rn;

  newton_divider_param #(.WIDTH(32), .ITERS(3), .SIGNED(0)) u_dut_u (
    .clk(clk), .rstn(rstn), .start(start), .num(num), .den(den),
    .available(avail_u), .done(done_u), .quot(quot_u), .rem(rem_u)
`ifdef NEWTON_DIV0_EN
    , .div0(div0_u)
`endif
  );

  newton_divider_param #(.WIDTH(32), .ITERS(3), .SIGNED(1)) u_dut_s (
    .clk(clk), .rstn(rstn), .start(start), .num(num), .den(den),
    .available(avail_s), .done(done_s), .quot(quot_s), .rem(rem_s)
`ifdef NEWTON_DIV0_EN
    , .div0(div0_s)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer division with the corner-case rules.
  function automatic logic [31:0] ref_q_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  function automatic logic [31:0] ref_r_u(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return a;
    return a % b;
  endfunction

  function automatic logic [31:0] ref_q_s(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (sb == 0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    return 32'(sa / sb);
  endfunction

  function automatic logic [31:0] ref_r_s(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (sb == 0) return a;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
    return 32'(sa % sb);
  endfunction

  // One division on both instances; noise scrambles start/num/den while busy.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int hold, input bit noise);
    int lat_u, lat_s, w;
    lat_u = 0;
    lat_s = 0;
    w = 0;
    while (!(avail_u && avail_s) && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("idle_avail", 32'(avail_u & avail_s), 32'd1);
    @(negedge clk);
    num = a;
    den = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("busy_avail", 32'(avail_u | avail_s), 32'd0);
    for (int k = 1; k <= 20 && (lat_u == 0 || lat_s == 0); k++) begin
      @(posedge clk);
      #1;
      if (done_u && lat_u == 0) lat_u = k;
      if (done_s && lat_s == 0) lat_s = k;
      if (noise && (lat_u == 0 || lat_s == 0)) begin
        num = $urandom;
        den = $urandom;
        start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b1;
    check("lat_u", 32'(lat_u), 32'd9);
    check("lat_s", 32'(lat_s), 32'd9);
    check("quot_u", quot_u, ref_q_u(a, b));
    check("rem_u", rem_u, ref_r_u(a, b));
    check("quot_s", quot_s, ref_q_s(a, b));
    check("rem_s", rem_s, ref_r_s(a, b));
`ifdef NEWTON_DIV0_EN
    check("div0_u", 32'(div0_u), 32'(b == 32'd0));
    check("div0_s", 32'(div0_s), 32'(b == 32'd0));
`endif
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
      end
      check("done_held", 32'(done_u & done_s), 32'd1);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_clr", 32'(done_u | done_s), 32'd0);
    check("avail_back", 32'(avail_u & avail_s), 32'd1);
`ifdef NEWTON_DIV0_EN
    check("div0_clr", 32'(div0_u | div0_s), 32'd0);
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rstn = 1'b1;
    start = 1'b0;
    num = '0;
    den = '0;
    #2 rstn = 1'b0;
    #1;
    check("rst_avail", 32'(avail_u & avail_s), 32'd1);
    check("rst_done", 32'(done_u | done_s), 32'd0);
    check("rst_quot", quot_u | quot_s, 32'd0);
    check("rst_rem", rem_u | rem_s, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Directed cases
    run_div(32'd100, 32'd7, 3, 1'b0);
    check("q_100_7", quot_u, 32'd14);
    check("r_100_7", rem_u, 32'd2);
    run_div(32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    check("q_s_m7_2", quot_s, 32'hFFFF_FFFD);
    check("r_s_m7_2", rem_s, 32'hFFFF_FFFF);
    run_div(32'd7, 32'hFFFF_FFFE, 0, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
    check("q_s_min", quot_s, 32'h8000_0000);
    run_div(32'd0, 32'd5, 0, 1'b0);
    run_div(32'd1, 32'h8000_0000, 0, 1'b0);
    run_div(32'h8000_0000, 32'd1, 0, 1'b1);
    run_div(32'd12345, 32'd12346, 0, 1'b1);
    run_div(32'd55, 32'd0, 2, 1'b0);
    check("q_div0", quot_u, 32'hFFFF_FFFF);
    check("r_div0", rem_u, 32'd55);

    // Reset while iterating
    @(negedge clk);
    num = 32'd100;
    den = 32'd3;
    start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_avail", 32'(avail_u & avail_s), 32'd1);
    check("mid_rst_done", 32'(done_u | done_s), 32'd0);
    check("mid_rst_quot", quot_u | quot_s, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    run_div(32'd9, 32'd3, 0, 1'b0);
    check("q_after_rst", quot_u, 32'd3);
    check("r_after_rst", rem_u, 32'd0);

    // Random pairs
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = 32'($urandom_range(0, 15)); end
        2: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
        3: begin ra = 32'($urandom_range(0, 100)); rb = $urandom; end
        4: begin
          ra = 32'h8000_0000 | 32'($urandom_range(0, 1));
          rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        default: begin ra = $urandom; rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7)); end
      endcase
      rh = $urandom_range(0, 2);
      rn = 1'($urandom_range(0, 1));
      run_div(ra, rb, rh, rn);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
